writeback_stage: RTL and testbench

Back end of the Execute stage. Accepts Execute results (primary ALU result, optional special result such as the RDX half of MUL/IMUL, destination registers, RIP, halt request) through a valid/ready handshake into a 2-entry buffer. Drains each entry into the 16 x 64-bit architectural register file over a single write port. Issues scoreboard busy-clear pulses, retire strobes and a retired-instruction count. Raises a sticky halt when a return-class instruction retires.

---
 rtl/writeback_stage.sv | 164 ++++++++++++++++
 tb/tb_writeback_stage.sv | 447 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_stage.sv
// writeback_stage: buffers Execute results in a small FIFO and retires them
// into the architectural register file, one write per cycle.
//
// state        | meaning
// S_IDLE       | buffer empty, nothing being written
// S_WR_PRIMARY | head entry: primary result write (retires unless a special result follows)
// S_WR_SPECIAL | head entry: special result write, always retires
// S_HALTED     | return-class instruction retired; absorbing until reset
module writeback_stage #(
  parameter int DATA_W = 64,
  parameter int REG_N  = 16,
  parameter int DEPTH  = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wbValidIn,
  output logic                       wbReadyOut,
  input  logic [DATA_W-1:0]          aluResultIn,
  input  logic [DATA_W-1:0]          aluResultSpecialIn,
  input  logic [$clog2(REG_N)-1:0]   destRegIn,
  input  logic                       writeRegValidIn,
  input  logic [$clog2(REG_N)-1:0]   destRegSpecialIn,
  input  logic                       destRegSpecialValidIn,
  input  logic [31:0]                currentRipIn,
  input  logic                       haltReqIn,
  output logic                       regWrEnOut,
  output logic [$clog2(REG_N)-1:0]   regWrAddrOut,
  output logic [DATA_W-1:0]          regWrDataOut,
  output logic [0:REG_N-1]           busyClrOut,
  output logic                       retireValidOut,
  output logic [31:0]                retireRipOut,
  output logic                       haltOut,
  output logic [63:0]                retiredCountOut
);

  localparam int AW = $clog2(REG_N);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_WR_PRIMARY = 2'd1,
    S_WR_SPECIAL = 2'd2,
    S_HALTED     = 2'd3
  } state_t;

  typedef struct packed {
    logic [DATA_W-1:0] res;
    logic [DATA_W-1:0] res_sp;
    logic [AW-1:0]     dst;
    logic [AW-1:0]     dst_sp;
    logic              wr_v;
    logic              sp_v;
    logic [31:0]       rip;
    logic              halt;
  } entry_t;

  state_t        r_state;
  entry_t        r_buf [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [PW:0]   r_count;
  logic [63:0]   r_retired_cnt;

  entry_t      w_head;
  entry_t      w_entry_in;
  logic        w_push;
  logic        w_retire;
  logic        w_enter_halt;
  logic [PW:0] w_count_nxt;

  assign w_head       = r_buf[r_rd_ptr];
  assign w_entry_in   = '{res: aluResultIn, res_sp: aluResultSpecialIn,
                          dst: destRegIn, dst_sp: destRegSpecialIn,
                          wr_v: writeRegValidIn, sp_v: destRegSpecialValidIn,
                          rip: currentRipIn, halt: haltReqIn};
  // Ready depends only on registered state (and reset), never on wbValidIn.
  assign wbReadyOut   = !reset && (r_count < DEPTH_C) && (r_state != S_HALTED);
  assign w_push       = wbValidIn && wbReadyOut;
  assign w_retire     = ((r_state == S_WR_PRIMARY) && !w_head.sp_v) || (r_state == S_WR_SPECIAL);
  assign w_enter_halt = w_retire && w_head.halt;
  assign w_count_nxt  = r_count + {{PW{1'b0}}, w_push} - {{PW{1'b0}}, w_retire};

  // Input FIFO: push at the tail, pop the head on retire; halting flushes it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_buf[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_buf[r_wr_ptr] <= w_entry_in;
        r_wr_ptr        <= r_wr_ptr + PW'(1);
      end
      if (w_retire) r_rd_ptr <= r_rd_ptr + PW'(1);
      r_count <= w_enter_halt ? '0 : w_count_nxt;
    end
  end

  // Sequencing of each head entry through its primary and special writes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:
          if (w_count_nxt != '0) r_state <= S_WR_PRIMARY;
        S_WR_PRIMARY:
          if (w_head.sp_v)              r_state <= S_WR_SPECIAL;
          else if (w_head.halt)         r_state <= S_HALTED;
          else if (w_count_nxt != '0)   r_state <= S_WR_PRIMARY;
          else                          r_state <= S_IDLE;
        S_WR_SPECIAL:
          if (w_head.halt)              r_state <= S_HALTED;
          else if (w_count_nxt != '0)   r_state <= S_WR_PRIMARY;
          else                          r_state <= S_IDLE;
        default:
          r_state <= S_HALTED;
      endcase
    end
  end

  // Retired-instruction counter, wraps naturally at 2^64.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         r_retired_cnt <= '0;
    else if (w_retire) r_retired_cnt <= r_retired_cnt + 64'd1;
  end

  // Register-file port and retire outputs decoded from state and buffer head.
  always_comb begin
    regWrEnOut     = 1'b0;
    regWrAddrOut   = '0;
    regWrDataOut   = '0;
    retireValidOut = w_retire;
    retireRipOut   = '0;
    case (r_state)
      S_WR_PRIMARY: begin
        regWrEnOut = w_head.wr_v;
        if (w_head.wr_v) begin
          regWrAddrOut = w_head.dst;
          regWrDataOut = w_head.res;
        end
      end
      S_WR_SPECIAL: begin
        regWrEnOut   = 1'b1;
        regWrAddrOut = w_head.dst_sp;
        regWrDataOut = w_head.res_sp;
      end
      default: ;
    endcase
    if (w_retire) retireRipOut = w_head.rip;
  end

  // Scoreboard clear follows every register write.
  always_comb begin
    busyClrOut = '0;
    if (regWrEnOut) busyClrOut[regWrAddrOut] = 1'b1;
  end

  assign haltOut         = (r_state == S_HALTED);
  assign retiredCountOut = r_retired_cnt;

endmodule

// File: tb/tb_writeback_stage.sv
// Testbench for writeback_stage: directed scenarios plus a randomized stream
// checked against an entry-level model of expected writes and retires.
module tb_writeback_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        wbValidIn;
  logic        wbReadyOut;
  logic [63:0] aluResultIn;
  logic [63:0] aluResultSpecialIn;
  logic [3:0]  destRegIn;
  logic        writeRegValidIn;
  logic [3:0]  destRegSpecialIn;
  logic        destRegSpecialValidIn;
  logic [31:0] currentRipIn;
  logic        haltReqIn;
  logic        regWrEnOut;
  logic [3:0]  regWrAddrOut;
  logic [63:0] regWrDataOut;
  logic [0:15] busyClrOut;
  logic        retireValidOut;
  logic [31:0] retireRipOut;
  logic        haltOut;
  logic [63:0] retiredCountOut;

  writeback_stage #(.DATA_W(64), .REG_N(16), .DEPTH(2)) dut (
    .clk(clk), .reset(reset), .wbValidIn(wbValidIn), .wbReadyOut(wbReadyOut),
    .aluResultIn(aluResultIn), .aluResultSpecialIn(aluResultSpecialIn),
    .destRegIn(destRegIn), .writeRegValidIn(writeRegValidIn),
    .destRegSpecialIn(destRegSpecialIn), .destRegSpecialValidIn(destRegSpecialValidIn),
    .currentRipIn(currentRipIn), .haltReqIn(haltReqIn),
    .regWrEnOut(regWrEnOut), .regWrAddrOut(regWrAddrOut), .regWrDataOut(regWrDataOut),
    .busyClrOut(busyClrOut), .retireValidOut(retireValidOut), .retireRipOut(retireRipOut),
    .haltOut(haltOut), .retiredCountOut(retiredCountOut)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] res;
    logic [63:0] res_sp;
    logic [3:0]  dst;
    logic [3:0]  dst_sp;
    logic        wr_v;
    logic        sp_v;
    logic        halt;
    logic [31:0] rip;
  } ent_t;

  // One observable cycle: a register write and/or a retire strobe.
  typedef struct packed {
    logic        en;
    logic [3:0]  addr;
    logic [63:0] data;
    logic [15:0] busy;
    logic        ret;
    logic [31:0] rip;
  } ev_t;

  int          n_pass = 0;
  int          n_total = 0;
  logic [63:0] exp_count = '0;
  ev_t         exp_q[$];

  function automatic ent_t mk(input logic [63:0] res, input logic [63:0] res_sp,
                              input logic [3:0] dst, input logic [3:0] dst_sp,
                              input logic wr_v, input logic sp_v,
                              input logic halt, input logic [31:0] rip);
    ent_t e;
    e.res = res; e.res_sp = res_sp; e.dst = dst; e.dst_sp = dst_sp;
    e.wr_v = wr_v; e.sp_v = sp_v; e.halt = halt; e.rip = rip;
    return e;
  endfunction

  function automatic ev_t mk_ev(input logic en, input logic [3:0] addr, input logic [63:0] data,
                                input logic ret, input logic [31:0] rip);
    ev_t v;
    v.en   = en;
    v.addr = en ? addr : 4'd0;
    v.data = en ? data : 64'd0;
    v.busy = en ? (16'h8000 >> addr) : 16'h0000;
    v.ret  = ret;
    v.rip  = ret ? rip : 32'd0;
    return v;
  endfunction

  // Reference model: an entry turns into its observable cycles in program order.
  function automatic void model_entry(input ent_t e);
    if (e.wr_v) exp_q.push_back(mk_ev(1'b1, e.dst, e.res, !e.sp_v, e.rip));
    if (e.sp_v) exp_q.push_back(mk_ev(1'b1, e.dst_sp, e.res_sp, 1'b1, e.rip));
    if (!e.wr_v && !e.sp_v) exp_q.push_back(mk_ev(1'b0, 4'd0, 64'd0, 1'b1, e.rip));
  endfunction

  function automatic ev_t observe();
    return mk_ev(regWrEnOut, regWrAddrOut, regWrDataOut, retireValidOut, retireRipOut)
           | {1'b0, 4'd0, 64'd0, 16'(busyClrOut), 1'b0, 32'd0} & {118{1'b0}}
           | observe_busy();
  endfunction

  function automatic ev_t observe_busy();
    ev_t v = '0;
    v.busy = busyClrOut;
    return v;
  endfunction

  function automatic ev_t observe_raw();
    ev_t v;
    v.en   = regWrEnOut;
    v.addr = regWrEnOut ? regWrAddrOut : 4'd0;
    v.data = regWrEnOut ? regWrDataOut : 64'd0;
    v.busy = busyClrOut;
    v.ret  = retireValidOut;
    v.rip  = retireRipOut;
    return v;
  endfunction

  task automatic drive(input ent_t e);
    wbValidIn = 1'b1;
    aluResultIn = e.res; aluResultSpecialIn = e.res_sp;
    destRegIn = e.dst; destRegSpecialIn = e.dst_sp;
    writeRegValidIn = e.wr_v; destRegSpecialValidIn = e.sp_v;
    haltReqIn = e.halt; currentRipIn = e.rip;
  endtask

  task automatic drive_idle();
    wbValidIn = 1'b0;
    aluResultIn = '0; aluResultSpecialIn = '0; destRegIn = '0; destRegSpecialIn = '0;
    writeRegValidIn = 1'b0; destRegSpecialValidIn = 1'b0; haltReqIn = 1'b0; currentRipIn = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive_idle();
    repeat (2) @(negedge clk);
    n_total++;
    if ({regWrEnOut, retireValidOut, haltOut, wbReadyOut, regWrAddrOut, regWrDataOut,
         busyClrOut, retireRipOut, retiredCountOut} !== '0)
      $display("FAIL reset_outputs: en=%b ret=%b halt=%b rdy=%b busy=%h cnt=%0d, all required 0",
               regWrEnOut, retireValidOut, haltOut, wbReadyOut, busyClrOut, retiredCountOut);
    else n_pass++;
    reset = 1'b0;
    #1;
    n_total++;
    if (wbReadyOut !== 1'b1) $display("FAIL ready_after_release: got %b, required 1", wbReadyOut);
    else n_pass++;
    exp_count = '0;
  endtask

  task automatic test_add();
    ev_t exp_v;
    @(negedge clk);
    drive(mk(64'h5, 64'h0, 4'd3, 4'd0, 1'b1, 1'b0, 1'b0, 32'h0040_0000));
    @(negedge clk);
    drive_idle();
    exp_v = '{en: 1'b1, addr: 4'd3, data: 64'h5, busy: 16'h1000, ret: 1'b1, rip: 32'h0040_0000};
    n_total++;
    if (observe_raw() !== exp_v) $display("FAIL add_write: got %h, required %h", observe_raw(), exp_v);
    else n_pass++;
    exp_count = exp_count + 1;
    @(negedge clk);
    n_total++;
    if ({retiredCountOut, regWrEnOut, retireValidOut} !== {exp_count, 2'b00})
      $display("FAIL add_count: got cnt=%0d en=%b ret=%b, required cnt=%0d en=0 ret=0",
               retiredCountOut, regWrEnOut, retireValidOut, exp_count);
    else n_pass++;
  endtask

  task automatic test_mul();
    ev_t exp_v;
    @(negedge clk);
    drive(mk(64'h2, 64'h1, 4'd0, 4'd2, 1'b1, 1'b1, 1'b0, 32'h0040_0010));
    @(negedge clk);
    drive_idle();
    exp_v = '{en: 1'b1, addr: 4'd0, data: 64'h2, busy: 16'h8000, ret: 1'b0, rip: 32'h0};
    n_total++;
    if (observe_raw() !== exp_v) $display("FAIL mul_primary: got %h, required %h", observe_raw(), exp_v);
    else n_pass++;
    @(negedge clk);
    exp_v = '{en: 1'b1, addr: 4'd2, data: 64'h1, busy: 16'h2000, ret: 1'b1, rip: 32'h0040_0010};
    n_total++;
    if (observe_raw() !== exp_v) $display("FAIL mul_special: got %h, required %h", observe_raw(), exp_v);
    else n_pass++;
    exp_count = exp_count + 1;
    @(negedge clk);
    n_total++;
    if (retiredCountOut !== exp_count)
      $display("FAIL mul_count: got %0d, required %0d", retiredCountOut, exp_count);
    else n_pass++;
  endtask

  task automatic test_same_reg();
    ev_t exp_v;
    @(negedge clk);
    drive(mk(64'hAAAA, 64'hBBBB, 4'd5, 4'd5, 1'b1, 1'b1, 1'b0, 32'h0040_0020));
    @(negedge clk);
    drive_idle();
    exp_v = '{en: 1'b1, addr: 4'd5, data: 64'hAAAA, busy: 16'h0400, ret: 1'b0, rip: 32'h0};
    n_total++;
    if (observe_raw() !== exp_v) $display("FAIL same_reg_first: got %h, required %h", observe_raw(), exp_v);
    else n_pass++;
    @(negedge clk);
    exp_v = '{en: 1'b1, addr: 4'd5, data: 64'hBBBB, busy: 16'h0400, ret: 1'b1, rip: 32'h0040_0020};
    n_total++;
    if (observe_raw() !== exp_v) $display("FAIL same_reg_last: got %h, required %h", observe_raw(), exp_v);
    else n_pass++;
    exp_count = exp_count + 1;
  endtask

  // Four plain results with valid held high: one write and retire every cycle.
  task automatic test_back_to_back();
    ent_t a[4];
    ev_t  exp_v;
    for (int i = 0; i < 4; i++)
      a[i] = mk({$urandom, $urandom}, 64'h0, 4'(4 + i), 4'd0, 1'b1, 1'b0, 1'b0, 32'h0050_0000 + 32'(4 * i));
    for (int k = 0; k <= 4; k++) begin
      @(negedge clk);
      if (k > 0) begin
        exp_v = mk_ev(1'b1, a[k-1].dst, a[k-1].res, 1'b1, a[k-1].rip);
        n_total++;
        if (observe_raw() !== exp_v)
          $display("FAIL b2b_write%0d: got %h, required %h", k - 1, observe_raw(), exp_v);
        else n_pass++;
      end
      if (k < 4) begin
        n_total++;
        if (wbReadyOut !== 1'b1) $display("FAIL b2b_ready%0d: got %b, required 1", k, wbReadyOut);
        else n_pass++;
        drive(a[k]);
      end else drive_idle();
    end
    exp_count = exp_count + 4;
    @(negedge clk);
    n_total++;
    if (retiredCountOut !== exp_count)
      $display("FAIL b2b_count: got %0d, required %0d", retiredCountOut, exp_count);
    else n_pass++;
  endtask

  // Three MULs offered back to back: the third must wait for the head to pop.
  task automatic test_backpressure();
    ent_t e[3];
    ev_t  got, want;
    int   idx = 0;
    logic prev_fire = 1'b0;
    logic done = 1'b0;
    for (int i = 0; i < 3; i++)
      e[i] = mk({$urandom, $urandom}, {$urandom, $urandom}, 4'(2 * i), 4'(2 * i + 1),
                1'b1, 1'b1, 1'b0, 32'h0060_0000 + 32'(8 * i));
    exp_q.delete();
    for (int cyc = 0; cyc < 30 && !done; cyc++) begin
      @(negedge clk);
      if (prev_fire) begin
        model_entry(e[idx]);
        idx++;
        exp_count = exp_count + 1;
      end
      got = observe_raw();
      if (got.en || got.ret) begin
        n_total++;
        if (exp_q.size() == 0) $display("FAIL bp_extra: got %h, required no activity", got);
        else begin
          want = exp_q.pop_front();
          if (got !== want) $display("FAIL bp_event: got %h, required %h", got, want);
          else n_pass++;
        end
      end
      if (cyc == 2) begin
        n_total++;
        if (wbReadyOut !== 1'b0) $display("FAIL bp_ready_full: got %b, required 0", wbReadyOut);
        else n_pass++;
      end
      if (idx < 3) drive(e[idx]);
      else drive_idle();
      prev_fire = (idx < 3) && wbReadyOut;
      done = (idx == 3) && (exp_q.size() == 0) && !prev_fire;
    end
    n_total++;
    if (!done) $display("FAIL bp_timeout: accepted %0d, pending %0d, required 3 and 0", idx, exp_q.size());
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (retiredCountOut !== exp_count)
      $display("FAIL bp_count: got %0d, required %0d", retiredCountOut, exp_count);
    else n_pass++;
  endtask

  task automatic test_random();
    localparam int N = 40;
    ent_t e[N];
    ev_t  got, want;
    int   idx = 0;
    int   errs = 0;
    int   nev = 0;
    logic prev_fire = 1'b0;
    logic done = 1'b0;
    for (int i = 0; i < N; i++)
      e[i] = mk({$urandom, $urandom}, {$urandom, $urandom}, 4'($urandom_range(0, 15)),
                4'($urandom_range(0, 15)), 1'($urandom_range(0, 3) != 0),
                1'($urandom_range(0, 2) == 0), 1'b0, $urandom);
    exp_q.delete();
    for (int cyc = 0; cyc < 600 && !done; cyc++) begin
      @(negedge clk);
      if (prev_fire) begin
        model_entry(e[idx]);
        idx++;
        exp_count = exp_count + 1;
      end
      got = observe_raw();
      if (got.en || got.ret) begin
        nev++;
        n_total++;
        if (exp_q.size() == 0) begin
          errs++;
          $display("FAIL rnd_extra: got %h, required no activity", got);
        end else begin
          want = exp_q.pop_front();
          if (got !== want) begin
            errs++;
            $display("FAIL rnd_event%0d: got %h, required %h", nev, got, want);
          end else n_pass++;
        end
      end
      if (idx < N && $urandom_range(0, 3) != 0) drive(e[idx]);
      else drive_idle();
      prev_fire = wbValidIn && wbReadyOut;
      done = (idx == N) && (exp_q.size() == 0) && !prev_fire;
    end
    n_total++;
    if (!done) $display("FAIL rnd_timeout: accepted %0d, pending %0d, required %0d and 0", idx, exp_q.size(), N);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (retiredCountOut !== exp_count)
      $display("FAIL rnd_count: got %0d, required %0d", retiredCountOut, exp_count);
    else n_pass++;
  endtask

  task automatic test_wrap();
    @(negedge clk);
    force dut.r_retired_cnt = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.r_retired_cnt;
    exp_count = 64'hFFFF_FFFF_FFFF_FFFF;
    @(negedge clk);
    drive(mk(64'h7, 64'h0, 4'd1, 4'd0, 1'b1, 1'b0, 1'b0, 32'h0070_0000));
    @(negedge clk);
    drive_idle();
    n_total++;
    if (retireValidOut !== 1'b1) $display("FAIL wrap_retire: got %b, required 1", retireValidOut);
    else n_pass++;
    exp_count = exp_count + 1;
    @(negedge clk);
    n_total++;
    if (retiredCountOut !== exp_count)
      $display("FAIL wrap_count: got %h, required %h", retiredCountOut, exp_count);
    else n_pass++;
  endtask

  task automatic test_halt();
    ev_t exp_v;
    @(negedge clk);
    drive(mk(64'h9, 64'h0, 4'd6, 4'd0, 1'b0, 1'b0, 1'b0, 32'h0080_0000));
    @(negedge clk);
    drive(mk(64'h0, 64'h0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b1, 32'h0080_0004));
    exp_v = mk_ev(1'b0, 4'd0, 64'd0, 1'b1, 32'h0080_0000);
    n_total++;
    if (observe_raw() !== exp_v) $display("FAIL halt_cmp: got %h, required %h", observe_raw(), exp_v);
    else n_pass++;
    @(negedge clk);
    drive_idle();
    exp_v = mk_ev(1'b0, 4'd0, 64'd0, 1'b1, 32'h0080_0004);
    n_total++;
    if (observe_raw() !== exp_v || haltOut !== 1'b0)
      $display("FAIL halt_ret: got %h halt=%b, required %h halt=0", observe_raw(), haltOut, exp_v);
    else n_pass++;
    exp_count = exp_count + 2;
    @(negedge clk);
    n_total++;
    if ({haltOut, wbReadyOut, retireValidOut} !== 3'b100)
      $display("FAIL halt_set: got halt=%b rdy=%b ret=%b, required 1 0 0", haltOut, wbReadyOut, retireValidOut);
    else n_pass++;
    drive(mk(64'h3, 64'h0, 4'd7, 4'd0, 1'b1, 1'b0, 1'b0, 32'h0080_0008));
    repeat (3) begin
      @(negedge clk);
      n_total++;
      if ({regWrEnOut, retireValidOut, haltOut} !== 3'b001 || retiredCountOut !== exp_count)
        $display("FAIL halt_absorb: got en=%b ret=%b halt=%b cnt=%0d, required 0 0 1 cnt=%0d",
                 regWrEnOut, retireValidOut, haltOut, retiredCountOut, exp_count);
      else n_pass++;
    end
    drive_idle();
  endtask

  task automatic test_reset_mid();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_count = '0;
    @(negedge clk);
    drive(mk(64'h11, 64'h22, 4'd8, 4'd9, 1'b1, 1'b1, 1'b0, 32'h0090_0000));
    @(negedge clk);
    drive_idle();
    n_total++;
    if ({regWrEnOut, regWrAddrOut, retireValidOut} !== {1'b1, 4'd8, 1'b0})
      $display("FAIL rst_mid_primary: got en=%b addr=%0d ret=%b, required 1 8 0",
               regWrEnOut, regWrAddrOut, retireValidOut);
    else n_pass++;
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_total++;
    if ({regWrEnOut, retireValidOut, wbReadyOut, busyClrOut, retireRipOut, regWrDataOut} !== '0)
      $display("FAIL rst_mid_outputs: got en=%b ret=%b rdy=%b busy=%h, required all 0",
               regWrEnOut, retireValidOut, wbReadyOut, busyClrOut);
    else n_pass++;
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_total++;
    if (wbReadyOut !== 1'b1) $display("FAIL rst_mid_ready: got %b, required 1", wbReadyOut);
    else n_pass++;
    repeat (3) begin
      @(negedge clk);
      n_total++;
      if ({regWrEnOut, retireValidOut} !== 2'b00 || retiredCountOut !== exp_count)
        $display("FAIL rst_mid_quiet: got en=%b ret=%b cnt=%0d, required 0 0 cnt=%0d",
                 regWrEnOut, retireValidOut, retiredCountOut, exp_count);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_mul();
    test_same_reg();
    test_back_to_back();
    test_backpressure();
    test_random();
    test_wrap();
    test_halt();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
